// File: rtl/param_icache.sv
// Direct-mapped instruction cache with configurable sets/words-per-block, multi-word fill FSM and flush.
// Define ICACHE_PERF_EN to add the hit_count/miss_count performance counters.
module param_icache #(
    parameter int SETS   = 16,
    parameter int WORDS  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [ADDR_W-1:0] imemaddr,
    input  logic              flush,
    output logic              ihit,
    output logic [DATA_W-1:0] imemload,
    input  logic              iwait,
    input  logic [DATA_W-1:0] iload,
    output logic              iREN,
    output logic [ADDR_W-1:0] iaddr
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int WO_W  = $clog2(WORDS);
    localparam int IX_W  = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IX_W - WO_W - 2;
    localparam int CNT_W = (WO_W > 0) ? WO_W : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_base;
    logic [SETS-1:0]   r_valid;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [DATA_W-1:0] r_data [SETS][WORDS];

    logic [IX_W-1:0]   w_req_idx;
    logic [TAG_W-1:0]  w_req_tag;
    logic [CNT_W-1:0]  w_req_woff;
    logic [IX_W-1:0]   w_fill_idx;
    logic [TAG_W-1:0]  w_fill_tag;
    logic              w_lookup;
    logic              w_hit;
    logic              w_miss;
    logic              w_last;
    logic              w_unused;

    assign w_req_idx  = imemaddr[IX_W+WO_W+1:WO_W+2];
    assign w_req_tag  = imemaddr[ADDR_W-1:ADDR_W-TAG_W];
    assign w_fill_idx = r_base[IX_W+WO_W+1:WO_W+2];
    assign w_fill_tag = r_base[ADDR_W-1:ADDR_W-TAG_W];
    assign w_unused   = ^imemaddr[1:0];

    generate
        if (WO_W > 0) begin : g_woff
            assign w_req_woff = imemaddr[WO_W+1:2];
        end else begin : g_nowoff
            assign w_req_woff = '0;
        end
    endgenerate

    // Lookup only counts in IDLE; a pending flush masks both hit and miss.
    assign w_lookup = (r_state == IDLE) && imemREN && !flush;
    assign w_hit    = w_lookup && r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
    assign w_miss   = w_lookup && !(r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag));
    assign w_last   = (r_cnt == CNT_W'(WORDS - 1));

    assign ihit     = w_hit;
    assign imemload = r_data[w_req_idx][w_req_woff];
    assign iREN     = (r_state == FILL);
    assign iaddr    = r_base + (ADDR_W'(r_cnt) << 2);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_base  <= '0;
            r_valid <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_tag[s] <= '0;
                for (int w = 0; w < WORDS; w++) begin
                    r_data[s][w] <= '0;
                end
            end
        end else if (flush) begin
            // Flush invalidates everything and abandons any fill in progress.
            r_valid <= '0;
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_miss) begin
                        r_state <= FILL;
                        r_cnt   <= '0;
                        r_base  <= {imemaddr[ADDR_W-1:WO_W+2], {(WO_W+2){1'b0}}};
                    end
                end
                FILL: begin
                    if (!iwait) begin
                        r_data[w_fill_idx][r_cnt] <= iload;
                        if (w_last) begin
                            r_valid[w_fill_idx] <= 1'b1;
                            r_tag[w_fill_idx]   <= w_fill_tag;
                            r_cnt               <= '0;
                            r_state             <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef ICACHE_PERF_EN
    // Counters free-run and wrap; flush deliberately leaves them alone.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (w_hit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (w_miss) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_param_icache.sv
// Randomized self-checking bench for param_icache with a transaction-level cache/memory model.
module tb_param_icache;

    localparam int SETS  = 16;
    localparam int WORDS = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          imemREN;
    logic [AW-1:0] imemaddr;
    logic          flush;
    logic          ihit;
    logic [DW-1:0] imemload;
    logic          iwait;
    logic [DW-1:0] iload;
    logic          iREN;
    logic [AW-1:0] iaddr;
`ifdef ICACHE_PERF_EN
    logic [31:0]   hit_count;
    logic [31:0]   miss_count;
`endif

    param_icache #(.SETS(SETS), .WORDS(WORDS), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .flush(flush),
        .ihit(ihit), .imemload(imemload), .iwait(iwait), .iload(iload),
        .iREN(iREN), .iaddr(iaddr)
`ifdef ICACHE_PERF_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    // Memory contents: word at byte address a is {a[15:0], ~a[15:0]}.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    always @* iload = memfn(iaddr);

    function automatic int unsigned f_idx(input logic [31:0] a);
        return (a / (4 * WORDS)) % SETS;
    endfunction

    function automatic int unsigned f_tag(input logic [31:0] a);
        return a / (4 * WORDS * SETS);
    endfunction

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    bit          m_valid [SETS];
    int unsigned m_tag   [SETS];
    bit          m_fill;
    logic [31:0] m_base;
    int          m_cnt;
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    always @(negedge CLK) begin
        bit exp_hit;
        if (!nRST) begin
            for (int s = 0; s < SETS; s++) begin
                m_valid[s] = 0;
                m_tag[s]   = 0;
            end
            m_fill = 0; m_base = 0; m_cnt = 0; m_hits = 0; m_misses = 0;
            chk("rst_ihit", ihit, 0);
            chk("rst_iREN", iREN, 0);
            chk("rst_iaddr", iaddr, 0);
            chk("rst_imemload", imemload, 0);
`ifdef ICACHE_PERF_EN
            chk("rst_hit_count", hit_count, 0);
            chk("rst_miss_count", miss_count, 0);
`endif
        end else begin
            exp_hit = !m_fill && imemREN && !flush &&
                      m_valid[f_idx(imemaddr)] && (m_tag[f_idx(imemaddr)] == f_tag(imemaddr));
            chk("ihit", ihit, exp_hit);
            chk("iREN", iREN, m_fill);
            if (exp_hit) chk("imemload", imemload, memfn({imemaddr[31:2], 2'b00}));
            if (m_fill) chk("iaddr", iaddr, m_base + 32'(4 * m_cnt));
`ifdef ICACHE_PERF_EN
            chk("hit_count", hit_count, m_hits);
            chk("miss_count", miss_count, m_misses);
`endif
            if (exp_hit) m_hits = m_hits + 1;
            if (flush) begin
                for (int s = 0; s < SETS; s++) m_valid[s] = 0;
                m_fill = 0;
                m_cnt  = 0;
            end else if (m_fill) begin
                if (!iwait) begin
                    m_cnt++;
                    if (m_cnt == WORDS) begin
                        m_valid[f_idx(m_base)] = 1;
                        m_tag[f_idx(m_base)]   = f_tag(m_base);
                        m_fill = 0;
                        m_cnt  = 0;
                    end
                end
            end else if (imemREN && !exp_hit) begin
                m_fill   = 1;
                m_base   = imemaddr - (imemaddr % (4 * WORDS));
                m_cnt    = 0;
                m_misses = m_misses + 1;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        step();
        step();
        nRST = 1'b1;
    endtask

    // Request a block and run until the cache is back in IDLE (bounded).
    task automatic do_fill(input logic [31:0] a);
        bit done;
        imemREN  = 1'b1;
        imemaddr = a;
        done     = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            step();
            if (!iREN) done = 1;
        end
        chk("fill_done", done, 1);
    endtask

    initial begin
        nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; flush = 1'b0; iwait = 1'b0;
        repeat (2) @(posedge CLK);
        #3;
        chk("lit_rst_ihit", ihit, 0);
        chk("lit_rst_imemload", imemload, 0);
        chk("lit_rst_iREN", iREN, 0);
        chk("lit_rst_iaddr", iaddr, 0);
        step();
        nRST = 1'b1;

        // Cold miss at 0x40
        imemREN = 1'b1; imemaddr = 32'h40;
        #2 chk("t1_cold_ihit", ihit, 0);
        step(); #2;
        chk("t1_iREN", iREN, 1);
        chk("t1_iaddr0", iaddr, 32'h40);
        step(); #2;
        chk("t1_iaddr1", iaddr, 32'h44);
        step(); #2;
        chk("t1_hit", ihit, 1);
        chk("t1_load", imemload, 32'h0040FFBF);
        chk("t1_iREN_off", iREN, 0);

        // Hit on the other word of the block
        imemaddr = 32'h44;
        #1;
        chk("t2_hit", ihit, 1);
        chk("t2_iREN", iREN, 0);
        chk("t2_load", imemload, 32'h0044FFBB);

        // Conflict at index 8
        step();
        imemaddr = 32'hC0;
        #1 chk("t3_miss", ihit, 0);
        step(); chk("t3_iaddr0", iaddr, 32'hC0);
        step(); chk("t3_iaddr1", iaddr, 32'hC4);
        step();
        chk("t3_hit", ihit, 1);
        chk("t3_load", imemload, 32'h00C0FF3F);
        imemaddr = 32'h40;
        #1 chk("t3_evicted", ihit, 0);
        do_fill(32'h40);
        chk("t3_refill_hit", ihit, 1);

        // Stall on the second word
        imemaddr = 32'hC0;
        step(); chk("t4_iaddr0", iaddr, 32'hC0);
        step(); chk("t4_iaddr1", iaddr, 32'hC4);
        iwait = 1'b1;
        repeat (4) begin
            step();
            chk("t4_hold_iaddr", iaddr, 32'hC4);
            chk("t4_hold_iREN", iREN, 1);
            chk("t4_hold_ihit", ihit, 0);
        end
        iwait = 1'b0;
        step();
        chk("t4_iREN_off", iREN, 0);
        chk("t4_hit", ihit, 1);
        chk("t4_load", imemload, 32'h00C0FF3F);

        // Flush mid-fill
        imemaddr = 32'h40;
        step();
        chk("t5_filling", iREN, 1);
        flush = 1'b1;
        #1 chk("t5_ihit", ihit, 0);
        step();
        flush = 1'b0;
        chk("t5_abort", iREN, 0);
        #1 chk("t5_miss40", ihit, 0);
        imemaddr = 32'hC0;
        #1 chk("t5_missC0", ihit, 0);
        imemREN = 1'b0;
        step();

        // Flush in IDLE with a pending miss
        imemREN = 1'b1; imemaddr = 32'h100; flush = 1'b1;
        #1 chk("t5b_ihit", ihit, 0);
        step();
        flush = 1'b0; imemREN = 1'b0;
        chk("t5b_no_fill", iREN, 0);

        // Flush masks a valid hit, then the line is gone
        do_fill(32'h40);
        chk("t5c_hit", ihit, 1);
        flush = 1'b1;
        #1 chk("t5c_forced", ihit, 0);
        step();
        flush = 1'b0;
        #1 chk("t5c_invalid", ihit, 0);
        imemREN = 1'b0;
        step();

`ifdef ICACHE_PERF_EN
        do_reset();
        do_fill(32'h40); imemREN = 1'b0;
        do_fill(32'h80); imemREN = 1'b0;
        step();
        imemREN = 1'b1;
        imemaddr = 32'h40; step();
        imemaddr = 32'h44; step();
        imemaddr = 32'h80; step();
        imemREN = 1'b0;
        flush = 1'b1; step();
        flush = 1'b0; step();
        chk("t6_hit_count", hit_count, 3);
        chk("t6_miss_count", miss_count, 2);
        nRST = 1'b0;
        #1;
        chk("t6_rst_hits", hit_count, 0);
        chk("t6_rst_misses", miss_count, 0);
        step();
        nRST = 1'b1;
`endif

        // Asynchronous reset mid-fill
        imemREN = 1'b1; imemaddr = 32'h200;
        step();
        chk("t7_filling", iREN, 1);
        nRST = 1'b0;
        #1 chk("t7_async_iREN", iREN, 0);
        step();
        nRST = 1'b1;

        // Randomized traffic over a few indices and conflicting tags
        for (int c = 0; c < 3000; c++) begin
            imemREN  = ($urandom % 4) != 0;
            imemaddr = (32'($urandom % 4) << 7) | (32'($urandom % 4) << 3) |
                       (32'($urandom % 2) << 2) | 32'($urandom % 4);
            iwait    = ($urandom % 10) < 3;
            flush    = ($urandom % 40) == 0;
            if (($urandom % 500) == 0) begin
                nRST = 1'b0;
                step();
                nRST = 1'b1;
            end else begin
                step();
            end
        end
        imemREN = 1'b0; flush = 1'b0; iwait = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
